// File: rtl/rv32i_boot_ctrl.sv
// rtl/rv32i_boot_ctrl.sv - boot sequencer: loads a byte-stream image into RAM, then releases the rv32i core
// Optional trailing payload checksum byte is enabled by defining RV32I_BOOT_CSUM_EN.
module rv32i_boot_ctrl #(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dout_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic        core_rst_no,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [32:0] CAPACITY = 33'd1 << MEM_AW;

  typedef enum logic [2:0] {S_HDR, S_DATA, S_WRITE, S_RUN, S_ERR, S_CSUM} state_t;

`ifdef RV32I_BOOT_CSUM_EN
  localparam state_t S_LAST = S_CSUM;
`else
  localparam state_t S_LAST = S_RUN;
`endif

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     hdr_q, hdr_d;
  logic [MEM_AW:0] n_q, n_d;
  logic [MEM_AW:0] word_idx_q, word_idx_d;
  logic [31:0]     word_q, word_d;
  logic            core_rst_q, core_rst_d;
`ifdef RV32I_BOOT_CSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif
  logic            rx_fire;
  logic            restart;
  logic [31:0]     hdr_word;

  assign rx_fire  = rx_valid_i & rx_ready_o;
  assign hdr_word = {rx_data_i, hdr_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_d      = hdr_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    core_rst_d = 1'b0;
    restart    = 1'b0;
`ifdef RV32I_BOOT_CSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_HDR: begin
        if (rx_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: hdr_d[7:0]   = rx_data_i;
            2'd1: hdr_d[15:8]  = rx_data_i;
            2'd2: hdr_d[23:16] = rx_data_i;
            default: begin
              if (hdr_word == 32'd0) begin
                state_d = S_LAST;
              end else if ({1'b0, hdr_word} > CAPACITY) begin
                state_d = S_ERR;
              end else begin
                state_d    = S_DATA;
                n_d        = hdr_word[MEM_AW:0];
                word_idx_d = '0;
              end
            end
          endcase
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
`ifdef RV32I_BOOT_CSUM_EN
          csum_d = csum_q ^ rx_data_i;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + (MEM_AW + 1)'(1);
        state_d    = (word_idx_d == n_q) ? S_LAST : S_DATA;
      end
`ifdef RV32I_BOOT_CSUM_EN
      S_CSUM: begin
        if (rx_fire) state_d = (rx_data_i == csum_q) ? S_RUN : S_ERR;
      end
`endif
      // core reset release lags RUN entry by one edge but drops on the restart edge
      S_RUN: begin
        core_rst_d = ~start_i;
        restart    = start_i;
      end
      S_ERR: restart = start_i;
      default: state_d = S_HDR;
    endcase

    if (restart) begin
      state_d    = S_HDR;
      byte_cnt_d = '0;
      hdr_d      = '0;
      n_d        = '0;
      word_idx_d = '0;
      word_d     = '0;
`ifdef RV32I_BOOT_CSUM_EN
      csum_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      hdr_q      <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      core_rst_q <= 1'b0;
`ifdef RV32I_BOOT_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_q      <= hdr_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      core_rst_q <= core_rst_d;
`ifdef RV32I_BOOT_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready_o  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_be_o    = {4{mem_we_o}};
  assign mem_addr_o  = LOAD_BASE + (32'(word_idx_q) << 2);
  assign mem_dout_o  = word_q;
  assign core_rst_no = core_rst_q;
  assign done_o      = (state_q == S_RUN);
  assign err_o       = (state_q == S_ERR);
  assign busy_o      = (state_q != S_RUN) && (state_q != S_ERR);

endmodule

// File: tb/tb_rv32i_boot_ctrl.sv
// tb/tb_rv32i_boot_ctrl.sv - directed table-driven bench for rv32i_boot_ctrl (MEM_AW=2)
// Build with RV32I_BOOT_CSUM_EN defined to exercise the checksum variant.
module tb_rv32i_boot_ctrl;

  localparam int unsigned MEM_AW = 2;
  localparam logic [31:0] LB     = 32'h0000_0000;
`ifdef RV32I_BOOT_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk, rst_i, start_i, rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o, mem_we_o, core_rst_no, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_dout_o;
  logic [3:0]  mem_be_o;

  rv32i_boot_ctrl #(.MEM_AW(MEM_AW), .LOAD_BASE(LB)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .core_rst_no(core_rst_no), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int base;

  // write-port monitor, the only writer of these variables
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  logic [3:0]  wb [64];
  int          wr_cnt = 0;
  int          rdy_bad = 0;
  always @(negedge clk) begin
    if (!rst_i && mem_we_o && wr_cnt < 64) begin
      wa[wr_cnt] <= mem_addr_o;
      wd[wr_cnt] <= mem_dout_o;
      wb[wr_cnt] <= mem_be_o;
      wr_cnt     <= wr_cnt + 1;
      if (rx_ready_o) rdy_bad <= rdy_bad + 1;
    end
  end

  typedef struct {
    logic [31:0]       n;
    logic [3:0][31:0]  w;
    int                gap;
    logic              bad;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // entered and left on a negedge; byte is taken at the posedge between
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waitc;
    rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    waitc = 0;
    while (!rx_ready_o && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx_ready_timeout: byte %h not accepted within 20 cycles", b);
    end
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_image(input logic [31:0] n, input logic [3:0][31:0] w, input int gap,
                            input bit payload);
    logic [7:0]  b;
    logic [31:0] wrd;
`ifdef RV32I_BOOT_CSUM_EN
    logic [7:0]  x;
    x = 8'h00;
`endif
    for (int k = 0; k < 4; k++) begin
      b = n[8*k +: 8];
      send_byte(b, gap);
    end
    if (payload) begin
      for (int i = 0; i < int'(n); i++) begin
        wrd = w[i];
        for (int k = 0; k < 4; k++) begin
          b = wrd[8*k +: 8];
`ifdef RV32I_BOOT_CSUM_EN
          x = x ^ b;
`endif
          send_byte(b, gap);
        end
      end
`ifdef RV32I_BOOT_CSUM_EN
      send_byte(x, gap);
`endif
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_core_held", 32'(core_rst_no), 32'd0);
    chk("start_busy", 32'(busy_o), 32'd1);
  endtask

  task automatic expect_ok(input int n, input logic [3:0][31:0] w, input int b0);
    logic [31:0] wrd;
    if (n != 0 && !CSUM) begin
      chk("last_write_we", 32'(mem_we_o), 32'd1);
      chk("last_write_be", 32'(mem_be_o), 32'hF);
      @(negedge clk);
    end
    chk("run_done", 32'(done_o), 32'd1);
    chk("run_core_lag", 32'(core_rst_no), 32'd0);
    @(negedge clk);
    chk("run_core_released", 32'(core_rst_no), 32'd1);
    chk("run_busy", 32'(busy_o), 32'd0);
    chk("run_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("run_err", 32'(err_o), 32'd0);
    chk("run_be_idle", 32'(mem_be_o), 32'd0);
    chk("write_count", 32'(wr_cnt - b0), 32'(n));
    for (int i = 0; i < n && i < 4; i++) begin
      wrd = w[i];
      chk("write_addr", wa[b0 + i], LB + 32'(4 * i));
      chk("write_data", wd[b0 + i], wrd);
      chk("write_be", 32'(wb[b0 + i]), 32'hF);
    end
  endtask

  task automatic expect_err(input int b0);
    chk("err_flag", 32'(err_o), 32'd1);
    chk("err_core_held", 32'(core_rst_no), 32'd0);
    chk("err_busy", 32'(busy_o), 32'd0);
    chk("err_rx_ready", 32'(rx_ready_o), 32'd0);
    chk("err_done", 32'(done_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("err_core_still_held", 32'(core_rst_no), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    vecs[0] = '{32'd1,          {96'h0, 32'h0000_0013},                                 0, 1'b0};
    vecs[1] = '{32'd2,          {64'h0, 32'h0000_0093, 32'hDEAD_BEEF},                  3, 1'b0};
    vecs[2] = '{32'd5,          {128'h0},                                               0, 1'b1};
    vecs[3] = '{32'd0,          {128'h0},                                               0, 1'b0};
    vecs[4] = '{32'h0001_0000,  {128'h0},                                               0, 1'b1};
    vecs[5] = '{32'd4,          {32'hF00D_F00D, 32'h99AA_BBCC, 32'h5566_7788, 32'h1122_3344}, 1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_core", 32'(core_rst_no), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_addr", mem_addr_o, LB);
    chk("rst_dout", mem_dout_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    rst_i = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      pulse_start();
      base = wr_cnt;
      send_image(vecs[v].n, vecs[v].w, vecs[v].gap, !vecs[v].bad);
      if (vecs[v].bad) begin
        expect_err(base);
        chk("err_no_writes", 32'(wr_cnt - base), 32'd0);
      end else begin
        expect_ok(int'(vecs[v].n), vecs[v].w, base);
      end
    end

    // start pulse mid-word is ignored
    pulse_start();
    base = wr_cnt;
    send_image(32'd1, 128'h0, 0, 1'b0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("data_start_busy", 32'(busy_o), 32'd1);
    chk("data_start_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("data_start_err", 32'(err_o), 32'd0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
`ifdef RV32I_BOOT_CSUM_EN
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0);
`endif
    expect_ok(1, {96'h0, 32'hDDCC_BBAA}, base);

    // asynchronous reset mid-word, then a fresh image
    pulse_start();
    send_image(32'd1, 128'h0, 0, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_core", 32'(core_rst_no), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd1);
    chk("midrst_rx_ready", 32'(rx_ready_o), 32'd1);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_we", 32'(mem_we_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    base = wr_cnt;
    send_image(32'd1, {96'h0, 32'hCAFE_F00D}, 0, 1'b1);
    expect_ok(1, {96'h0, 32'hCAFE_F00D}, base);

`ifdef RV32I_BOOT_CSUM_EN
    pulse_start();
    base = wr_cnt;
    send_image(32'd1, {96'h0, 32'h0403_0201}, 0, 1'b1);
    expect_ok(1, {96'h0, 32'h0403_0201}, base);
    pulse_start();
    base = wr_cnt;
    send_image(32'd1, 128'h0, 0, 1'b0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    expect_err(base);
    chk("csum_bad_write_count", 32'(wr_cnt - base), 32'd1);
`endif

    chk("rx_ready_low_in_write", 32'(rdy_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
